// File: rtl/mef_vedacao_if.sv
// Handshake bundle between the main line FSM and the sealing station.
// The master drives the requests; the slave, the sealer, returns status.
interface mef_vedacao_if #(
   parameter int STOCK_W = 4
) ();
   logic               start;
   logic               pos_ve;
   logic               reabastecer;
   logic               dispensa;
   logic               prensa;
   logic               ve_done;
   logic               alarme;
   logic [STOCK_W-1:0] estoque;

   modport master (
      output start, pos_ve, reabastecer,
      input  dispensa, prensa, ve_done, alarme, estoque
   );

   modport slave (
      input  start, pos_ve, reabastecer,
      output dispensa, prensa, ve_done, alarme, estoque
   );
endinterface

// File: rtl/mef_vedacao.sv
// Sealing station FSM: dispenses one cap, holds the press for PRESS_CYCLES,
// then handshakes completion; blocks with an alarm when the magazine is empty.
module mef_vedacao #(
   parameter int PRESS_CYCLES = 4,
   parameter int STOCK_MAX    = 15,
   parameter int STOCK_W      = 4
) (
   input logic          clk,
   input logic          reset,
   mef_vedacao_if.slave vd
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DISP  = 3'd1,
      PRESS = 3'd2,
      DONE  = 3'd3,
      EMPTY = 3'd4
   } state_t;

   localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);
   localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);
   localparam logic [STOCK_W-1:0] STOCK_NONE = {STOCK_W{1'b0}};
   localparam logic [7:0]         TIMER_LOAD = 8'(PRESS_CYCLES - 1);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [7:0]         timer_r;
   logic [7:0]         timer_nxt_s;
   logic [STOCK_W-1:0] estoque_r;
   logic [STOCK_W-1:0] estoque_nxt_s;
   logic               dispensa_r;
   logic               prensa_r;
   logic               ve_done_r;
   logic               alarme_r;

   // Next-state, press timer and magazine count decode
   always_comb begin
      state_nxt_s   = state_r;
      timer_nxt_s   = timer_r;
      estoque_nxt_s = estoque_r;
      case (state_r)
         IDLE: begin
            timer_nxt_s = 8'd0;
            if (vd.reabastecer) estoque_nxt_s = STOCK_FULL;
            else                estoque_nxt_s = estoque_r;
            // A refill in the same cycle as a request counts as stock available
            if (vd.start && vd.pos_ve) begin
               if ((estoque_r != STOCK_NONE) || vd.reabastecer) state_nxt_s = DISP;
               else                                             state_nxt_s = EMPTY;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DISP: begin
            if (estoque_r != STOCK_NONE) estoque_nxt_s = estoque_r - STOCK_ONE;
            else                         estoque_nxt_s = estoque_r;
            if (vd.start) begin
               state_nxt_s = PRESS;
               timer_nxt_s = TIMER_LOAD;
            end else begin
               state_nxt_s = IDLE;
               timer_nxt_s = 8'd0;
            end
         end
         PRESS: begin
            if (!vd.start) begin
               state_nxt_s = IDLE;
               timer_nxt_s = 8'd0;
            end else if (timer_r == 8'd0) begin
               state_nxt_s = DONE;
            end else begin
               timer_nxt_s = timer_r - 8'd1;
            end
         end
         DONE: begin
            if (vd.start && vd.pos_ve) state_nxt_s = DONE;
            else                       state_nxt_s = IDLE;
         end
         EMPTY: begin
            if (vd.reabastecer) begin
               estoque_nxt_s = STOCK_FULL;
               state_nxt_s   = IDLE;
            end else if (!vd.start) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            timer_nxt_s = 8'd0;
         end
      endcase
   end

   // State, counters and outputs registered from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         timer_r     <= 8'd0;
         estoque_r   <= STOCK_FULL;
         dispensa_r  <= 1'b0;
         prensa_r    <= 1'b0;
         ve_done_r   <= 1'b0;
         alarme_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         timer_r     <= timer_nxt_s;
         estoque_r   <= estoque_nxt_s;
         dispensa_r  <= (state_nxt_s == DISP);
         prensa_r    <= (state_nxt_s == PRESS);
         ve_done_r   <= (state_nxt_s == DONE);
         alarme_r    <= (state_nxt_s == EMPTY);
      end
   end

   assign vd.dispensa = dispensa_r;
   assign vd.prensa   = prensa_r;
   assign vd.ve_done  = ve_done_r;
   assign vd.alarme   = alarme_r;
   assign vd.estoque  = estoque_r;
endmodule

// File: tb/tb_mef_vedacao.sv
// Directed bench for the sealing station with PRESS_CYCLES=4, STOCK_MAX=3.
// Outputs are sampled 1 time unit after each rising edge, as {dispensa,prensa,ve_done,alarme}.
module tb_mef_vedacao;
   localparam int PRESS_CYCLES = 4;
   localparam int STOCK_MAX    = 3;
   localparam int STOCK_W      = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] seal_exp [0:6] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010};

   mef_vedacao_if #(.STOCK_W(STOCK_W)) vif ();

   mef_vedacao #(
      .PRESS_CYCLES(PRESS_CYCLES),
      .STOCK_MAX   (STOCK_MAX),
      .STOCK_W     (STOCK_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .vd   (vif)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] outs();
      return {vif.dispensa, vif.prensa, vif.ve_done, vif.alarme};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_seal();
      vif.pos_ve = 1'b1;
      repeat (PRESS_CYCLES + 2) tick();
      vif.pos_ve = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vif.start = 1'b0;
      vif.pos_ve = 1'b0;
      vif.reabastecer = 1'b0;
      tick();
      tick();
      checks++;
      if (outs() !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outs got %b want %b", outs(), 4'b0000);
      end
      checks++;
      if (vif.estoque !== 4'd3) begin
         errors++;
         $display("FAIL reset_estoque got %0d want %0d", vif.estoque, 3);
      end
      reset = 1'b0;
      vif.start = 1'b1;
      tick();
   endtask

   task automatic test_normal_seal();
      vif.pos_ve = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (outs() !== seal_exp[i]) begin
            errors++;
            $display("FAIL normal_cycle%0d got %b want %b", i, outs(), seal_exp[i]);
         end
      end
      vif.pos_ve = 1'b0;
      tick();
      checks++;
      if (outs() !== 4'b0000) begin
         errors++;
         $display("FAIL normal_release got %b want %b", outs(), 4'b0000);
      end
      checks++;
      if (vif.estoque !== 4'd2) begin
         errors++;
         $display("FAIL normal_estoque got %0d want %0d", vif.estoque, 2);
      end
   endtask

   task automatic test_exhaustion();
      do_seal();
      do_seal();
      checks++;
      if (vif.estoque !== 4'd0) begin
         errors++;
         $display("FAIL exhaust_estoque got %0d want %0d", vif.estoque, 0);
      end
      vif.pos_ve = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (outs() !== 4'b0001) begin
            errors++;
            $display("FAIL exhaust_empty%0d got %b want %b", i, outs(), 4'b0001);
         end
      end
      // Refill and line stop in the same cycle while EMPTY
      vif.reabastecer = 1'b1;
      vif.start = 1'b0;
      tick();
      vif.reabastecer = 1'b0;
      vif.start = 1'b1;
      checks++;
      if (outs() !== 4'b0000 || vif.estoque !== 4'd3) begin
         errors++;
         $display("FAIL exhaust_refill got %b/%0d want %b/%0d", outs(), vif.estoque, 4'b0000, 3);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (outs() !== seal_exp[i]) begin
            errors++;
            $display("FAIL exhaust_seal%0d got %b want %b", i, outs(), seal_exp[i]);
         end
      end
      vif.pos_ve = 1'b0;
      tick();
      checks++;
      if (vif.estoque !== 4'd2) begin
         errors++;
         $display("FAIL exhaust_after got %0d want %0d", vif.estoque, 2);
      end
   endtask

   task automatic test_abort();
      vif.pos_ve = 1'b1;
      tick();
      tick();
      tick();
      checks++;
      if (outs() !== 4'b0100) begin
         errors++;
         $display("FAIL abort_press2 got %b want %b", outs(), 4'b0100);
      end
      vif.start = 1'b0;
      tick();
      checks++;
      if (outs() !== 4'b0000 || vif.estoque !== 4'd1) begin
         errors++;
         $display("FAIL abort_drop got %b/%0d want %b/%0d", outs(), vif.estoque, 4'b0000, 1);
      end
      tick();
      checks++;
      if (outs() !== 4'b0000) begin
         errors++;
         $display("FAIL abort_hold got %b want %b", outs(), 4'b0000);
      end
      vif.pos_ve = 1'b0;
      vif.start = 1'b1;
      tick();
   endtask

   task automatic test_refill_idle();
      vif.reabastecer = 1'b1;
      tick();
      vif.reabastecer = 1'b0;
      checks++;
      if (vif.estoque !== 4'd3 || outs() !== 4'b0000) begin
         errors++;
         $display("FAIL refill_idle got %0d/%b want %0d/%b", vif.estoque, outs(), 3, 4'b0000);
      end
   endtask

   task automatic test_handshake_hold();
      int disp_count = 0;
      logic [3:0] exp_v;
      vif.pos_ve = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0)      exp_v = 4'b1000;
         else if (i < 5)  exp_v = 4'b0100;
         else             exp_v = 4'b0010;
         if (vif.dispensa === 1'b1) disp_count++;
         checks++;
         if (outs() !== exp_v) begin
            errors++;
            $display("FAIL hold_cycle%0d got %b want %b", i, outs(), exp_v);
         end
      end
      checks++;
      if (disp_count != 1) begin
         errors++;
         $display("FAIL hold_dispense_count got %0d want %0d", disp_count, 1);
      end
      vif.pos_ve = 1'b0;
      tick();
      checks++;
      if (outs() !== 4'b0000 || vif.estoque !== 4'd2) begin
         errors++;
         $display("FAIL hold_release got %b/%0d want %b/%0d", outs(), vif.estoque, 4'b0000, 2);
      end
   endtask

   task automatic test_refill_press();
      vif.pos_ve = 1'b1;
      tick();
      tick();
      vif.reabastecer = 1'b1;
      tick();
      vif.reabastecer = 1'b0;
      checks++;
      if (vif.estoque !== 4'd1 || outs() !== 4'b0100) begin
         errors++;
         $display("FAIL refill_press got %0d/%b want %0d/%b", vif.estoque, outs(), 1, 4'b0100);
      end
      tick();
      tick();
      tick();
      checks++;
      if (outs() !== 4'b0010) begin
         errors++;
         $display("FAIL refill_press_done got %b want %b", outs(), 4'b0010);
      end
      vif.pos_ve = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      vif.pos_ve = 1'b1;
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 4'b0000 || vif.estoque !== 4'd3) begin
         errors++;
         $display("FAIL async_reset got %b/%0d want %b/%0d", outs(), vif.estoque, 4'b0000, 3);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (outs() !== seal_exp[i]) begin
            errors++;
            $display("FAIL post_reset_cycle%0d got %b want %b", i, outs(), seal_exp[i]);
         end
      end
      vif.pos_ve = 1'b0;
      tick();
      checks++;
      if (vif.estoque !== 4'd2) begin
         errors++;
         $display("FAIL post_reset_estoque got %0d want %0d", vif.estoque, 2);
      end
   endtask

   task automatic test_early_release();
      vif.pos_ve = 1'b1;
      tick();
      vif.pos_ve = 1'b0;
      for (int i = 1; i < 7; i++) begin
         tick();
         checks++;
         if (i < 6 && outs() !== seal_exp[i]) begin
            errors++;
            $display("FAIL early_cycle%0d got %b want %b", i, outs(), seal_exp[i]);
         end else if (i == 6 && outs() !== 4'b0000) begin
            errors++;
            $display("FAIL early_exit got %b want %b", outs(), 4'b0000);
         end
      end
      checks++;
      if (vif.estoque !== 4'd1) begin
         errors++;
         $display("FAIL early_estoque got %0d want %0d", vif.estoque, 1);
      end
   endtask

   initial begin
      test_reset();
      test_normal_seal();
      test_exhaustion();
      test_abort();
      test_refill_idle();
      test_handshake_hold();
      test_refill_press();
      test_async_reset();
      test_early_release();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mef_vedacao.md
MEF_VEDACAO -- requirements
Module: mef_vedacao

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 4, number of clock cycles the sealing press stays down (legal 1..255).
REQ-002 SHALL have parameter STOCK_MAX, default 15, cap-magazine capacity after refill (legal 1..255).
REQ-003 SHALL have parameter STOCK_W, default 4, width of the stock counter (2^STOCK_W-1 >= STOCK_MAX).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  line enable; 0 aborts any sealing in progress.
REQ-007 pos_ve  input  1  sealing request from main FSM; level, high while the bottle sits at the sealing station.
REQ-008 reabastecer  input  1  magazine refill strobe; level-sampled each cycle.
REQ-009 dispensa  output  1  cap dispense pulse.
REQ-010 prensa  output  1  sealing press actuator; 1 = press down.
REQ-011 ve_done  output  1  sealing complete, returned to main FSM.
REQ-012 alarme  output  1  magazine empty, sealing blocked.
REQ-013 estoque  output  STOCK_W  caps remaining in the magazine.

Function
REQ-014 SHALL be a Moore FSM, states IDLE, DISP, PRESS, DONE, EMPTY; all outputs decoded from registered state/counters only.
REQ-015 IDLE: all 1-bit outputs 0; on pos_ve=1 and start=1 -> DISP if estoque>0, else EMPTY.
REQ-016 DISP: lasts exactly 1 cycle; dispensa=1; estoque decrements by 1 on exit; -> PRESS.
REQ-017 PRESS: prensa=1 for exactly PRESS_CYCLES consecutive cycles via an internal timer loaded on DISP exit; -> DONE when the timer expires.
REQ-018 DONE: ve_done=1; stays in DONE while pos_ve=1; -> IDLE on the first cycle pos_ve=0 (4-phase handshake, no resealing of the same bottle).
REQ-019 Latency: pos_ve sampled high in IDLE at edge N -> dispensa high during cycle N+1, prensa high cycles N+2..N+1+PRESS_CYCLES, ve_done high from cycle N+2+PRESS_CYCLES.
REQ-020 EMPTY: alarme=1, prensa=0; on reabastecer=1 estoque loads STOCK_MAX and FSM -> IDLE (request re-evaluated next cycle).
REQ-021 reabastecer=1 in IDLE SHALL load estoque=STOCK_MAX; in DISP, PRESS or DONE it SHALL be ignored.
REQ-022 start=0 in DISP, PRESS, DONE or EMPTY SHALL force IDLE on the next edge; prensa drops that edge; estoque keeps its value (a cap dispensed in DISP stays counted as used).
REQ-023 start=0 and reabastecer=1 in the same cycle in EMPTY: estoque SHALL load STOCK_MAX and FSM -> IDLE.
REQ-024 estoque SHALL never wrap; decrement only from DISP, which is only reachable with estoque>0.
REQ-025 pos_ve falling during DISP or PRESS SHALL NOT abort the cycle; sealing completes and DONE exits immediately to IDLE after one cycle with ve_done=1.
REQ-026 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, timer=0, estoque=STOCK_MAX, dispensa=prensa=ve_done=alarme=0.
REQ-028 reset mid-PRESS SHALL drop prensa immediately (asynchronously) without asserting ve_done.
REQ-029 After reset release the first request is accepted on the first rising edge with reset=0.

Verification (PRESS_CYCLES=4, STOCK_MAX=3)
REQ-030 Normal seal: start=1, pos_ve rises before edge 0 -> dispensa cycle 1, prensa cycles 2-5, ve_done from cycle 6; pos_ve drops cycle 7 -> IDLE, estoque 3->2.
REQ-031 Exhaustion: 3 complete seals -> estoque=0; 4th pos_ve -> EMPTY, alarme=1, no dispensa/prensa; reabastecer 1 cycle -> estoque=3, alarme=0, seal proceeds.
REQ-032 Abort: start=0 during 2nd PRESS cycle -> prensa=0 next edge, no ve_done, estoque already decremented by 1, state IDLE.
REQ-033 Handshake hold: keep pos_ve=1 for 10 cycles after ve_done -> ve_done stays 1, single dispensa pulse only, no second seal.
REQ-034 Async reset mid-PRESS -> prensa=0 before the next edge, estoque=3, ve_done=0; fresh request after release gives REQ-030 timing.
REQ-035 Refill in IDLE with estoque=1 -> estoque=3; refill pulse during PRESS -> estoque unchanged.
